// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, req/gnt/rvalid memory port, prefetch FIFO and
// valid/ready handoff to IF-ID. Redirects flush buffered work and squash in-flight replies.
module instr_fetch #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        fetch_valid_o,
  input  logic        fetch_ready_i,
  output logic [31:0] fetch_rdata_o,
  output logic [31:0] fetch_addr_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } fetch_entry_t;

  logic [31:0]  pc_q, pc_d;
  logic [31:0]  aq_mem_q [DEPTH];
  ptr_t         aq_rptr_q, aq_rptr_d, aq_wptr_q, aq_wptr_d;
  fetch_entry_t ff_mem_q [DEPTH];
  ptr_t         ff_rptr_q, ff_rptr_d, ff_wptr_q, ff_wptr_d;
  cnt_t         ff_cnt_q, ff_cnt_d;
  cnt_t         outstanding_q, outstanding_d;
  cnt_t         discard_q, discard_d;
  fetch_entry_t head_q, head_d;

  logic [SUM_W-1:0] inflight_sum;
  logic             handshake, response, drop, ff_push, ff_pop;
  fetch_entry_t     push_entry;

  // Low address bits of a redirect target are defined as don't-care.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc_i[1:0];

  // Squashed requests still occupy capacity until their responses drain.
  assign inflight_sum = SUM_W'(outstanding_q) + SUM_W'(ff_cnt_q);
  assign imem_req_o   = !rst_i && !redirect_i && (inflight_sum < SUM_W'(DEPTH));
  assign imem_addr_o  = {pc_q[31:2], 2'b00};

  assign handshake  = imem_req_o && imem_gnt_i;
  assign response   = imem_rvalid_i && (outstanding_q != '0);
  assign drop       = response && (discard_q != '0);
  assign ff_push    = response && !drop;
  assign ff_pop     = (ff_cnt_q != '0) && fetch_ready_i;
  assign push_entry = '{addr: aq_mem_q[aq_rptr_q], data: imem_rdata_i};

  assign fetch_valid_o = !rst_i && (ff_cnt_q != '0);
  assign fetch_rdata_o = rst_i ? 32'h0 : head_q.data;
  assign fetch_addr_o  = rst_i ? 32'h0 : head_q.addr;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    pc_d          = pc_q;
    aq_rptr_d     = aq_rptr_q;
    aq_wptr_d     = aq_wptr_q;
    ff_rptr_d     = ff_rptr_q;
    ff_wptr_d     = ff_wptr_q;
    ff_cnt_d      = ff_cnt_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    head_d        = head_q;

    if (handshake) begin
      pc_d      = pc_q + 32'd4;
      aq_wptr_d = aq_wptr_q + ptr_t'(1);
    end

    unique case ({handshake, response})
      2'b10:   outstanding_d = outstanding_q + cnt_t'(1);
      2'b01:   outstanding_d = outstanding_q - cnt_t'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (drop) discard_d = discard_q - cnt_t'(1);

    if (ff_push) begin
      aq_rptr_d = aq_rptr_q + ptr_t'(1);
      ff_wptr_d = ff_wptr_q + ptr_t'(1);
    end
    if (ff_pop) ff_rptr_d = ff_rptr_q + ptr_t'(1);

    unique case ({ff_push, ff_pop})
      2'b10:   ff_cnt_d = ff_cnt_q + cnt_t'(1);
      2'b01:   ff_cnt_d = ff_cnt_q - cnt_t'(1);
      default: ff_cnt_d = ff_cnt_q;
    endcase

    if (redirect_i) begin
      pc_d      = {redirect_pc_i[31:2], 2'b00};
      discard_d = outstanding_d;
      aq_rptr_d = '0;
      aq_wptr_d = '0;
      ff_rptr_d = '0;
      ff_wptr_d = '0;
      ff_cnt_d  = '0;
    end

    // The head register follows the post-update FIFO head and holds when it empties.
    if (ff_cnt_d != '0) begin
      if (ff_push && (ff_rptr_d == ff_wptr_q)) head_d = push_entry;
      else                                     head_d = ff_mem_q[ff_rptr_d];
    end
  end

  // NOTE: storage arrays are not reset; the pointers and counts qualify every read.
  always_ff @(posedge clk_i) begin
    if (handshake) aq_mem_q[aq_wptr_q] <= pc_q;
    if (ff_push)   ff_mem_q[ff_wptr_q] <= push_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q          <= BOOT_ADDR;
      aq_rptr_q     <= '0;
      aq_wptr_q     <= '0;
      ff_rptr_q     <= '0;
      ff_wptr_q     <= '0;
      ff_cnt_q      <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      head_q        <= '0;
    end else begin
      pc_q          <= pc_d;
      aq_rptr_q     <= aq_rptr_d;
      aq_wptr_q     <= aq_wptr_d;
      ff_rptr_q     <= ff_rptr_d;
      ff_wptr_q     <= ff_wptr_d;
      ff_cnt_q      <= ff_cnt_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      head_q        <= head_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a memory responder and a fetch monitor pop
// expected grant addresses and fetched instructions queued by directed stimulus.
module tb_instr_fetch;

  localparam logic [31:0] BOOT = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        fetch_valid_o;
  logic        fetch_ready_i;
  logic [31:0] fetch_rdata_o;
  logic [31:0] fetch_addr_o;

  instr_fetch #(.BOOT_ADDR(BOOT), .DEPTH(2)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .fetch_valid_o (fetch_valid_o),
    .fetch_ready_i (fetch_ready_i),
    .fetch_rdata_o (fetch_rdata_o),
    .fetch_addr_o  (fetch_addr_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  int          checks = 0;
  int          errors = 0;
  pend_t       pend[$];
  logic [31:0] exp_gnt[$];
  logic [31:0] sb[$];
  int          budget  = 0;
  bit          resp_en = 1'b1;
  int          lat     = 1;
  int          cyc     = 0;

  assign imem_gnt_i = (budget > 0);

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0BAD_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while ((sb.size() != 0 || exp_gnt.size() != 0) && n < max_cycles) begin
      @(negedge clk_i);
      n++;
    end
    check("drain_empty", 64'(sb.size() + exp_gnt.size()), 64'd0);
    repeat (3) step();
  endtask

  // Memory responder: records grants, answers in order after lat cycles.
  initial begin : responder
    pend_t       p;
    logic [31:0] e;
    bit          hs_seen;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    forever begin
      @(negedge clk_i);
      hs_seen = imem_req_o && imem_gnt_i;
      if (hs_seen) begin
        pend.push_back('{addr: imem_addr_o, due: cyc + lat});
        if (exp_gnt.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL grant_unexpected: got addr %h, no grant expected", imem_addr_o);
        end else begin
          e = exp_gnt.pop_front();
          check("grant_addr", 64'(imem_addr_o), 64'(e));
        end
      end
      @(posedge clk_i);
      #3;
      cyc++;
      if (hs_seen) budget--;
      if (resp_en && pend.size() > 0 && pend[0].due <= cyc) begin
        p = pend.pop_front();
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(p.addr);
      end else begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
      end
    end
  end

  // Fetch monitor: every accepted instruction must match the scoreboard head.
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk_i);
      if (fetch_valid_o && fetch_ready_i) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fetch_unexpected: got addr %h data %h, none expected", fetch_addr_o, fetch_rdata_o);
        end else begin
          e = sb.pop_front();
          check("fetch_addr", 64'(fetch_addr_o), 64'(e));
          check("fetch_data", 64'(fetch_rdata_o), 64'(mem_word(e)));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    rst_i         = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    fetch_ready_i = 1'b1;

    // Reset state
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_req",   64'(imem_req_o),    64'd0);
    check("rst_valid", 64'(fetch_valid_o), 64'd0);
    check("rst_rdata", 64'(fetch_rdata_o), 64'd0);
    check("rst_addr",  64'(fetch_addr_o),  64'd0);

    // Streaming from BOOT_ADDR with gnt always on, rvalid one cycle later
    step();
    rst_i  = 1'b0;
    budget = 8;
    for (int i = 0; i < 8; i++) begin
      exp_gnt.push_back(32'(i * 4));
      sb.push_back(32'(i * 4));
    end
    @(negedge clk_i);
    check("first_req",  64'(imem_req_o),    64'd1);
    check("first_addr", 64'(imem_addr_o),   64'(BOOT));
    check("lat_v0",     64'(fetch_valid_o), 64'd0);
    @(negedge clk_i);
    check("lat_v1", 64'(fetch_valid_o), 64'd0);
    @(negedge clk_i);
    check("lat_v2", 64'(fetch_valid_o), 64'd1);
    wait_drain(100);

    // Backpressure: two grants fill capacity, req stays low until ready
    fetch_ready_i = 1'b0;
    budget        = 4;
    for (int i = 0; i < 4; i++) begin
      exp_gnt.push_back(32'h20 + 32'(i * 4));
      sb.push_back(32'h20 + 32'(i * 4));
    end
    @(negedge clk_i);
    @(negedge clk_i);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("bp_req_low", 64'(imem_req_o), 64'd0);
    end
    check("bp_valid", 64'(fetch_valid_o), 64'd1);
    check("bp_head",  64'(fetch_addr_o),  64'h20);
    step();
    fetch_ready_i = 1'b1;
    wait_drain(100);

    // Redirect with two requests in flight: both replies must be squashed
    resp_en = 1'b0;
    budget  = 2;
    exp_gnt.push_back(32'h30);
    exp_gnt.push_back(32'h34);
    step();
    step();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_1002;
    step();
    redirect_i = 1'b0;
    resp_en    = 1'b1;
    budget     = 2;
    exp_gnt.push_back(32'h1000);
    exp_gnt.push_back(32'h1004);
    sb.push_back(32'h1000);
    sb.push_back(32'h1004);
    @(negedge clk_i);
    check("redir_valid_low", 64'(fetch_valid_o), 64'd0);
    check("redir_req_full",  64'(imem_req_o),    64'd0);
    wait_drain(100);

    // Grant withheld: request and address stay put
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("stall_req",  64'(imem_req_o),  64'd1);
      check("stall_addr", 64'(imem_addr_o), 64'h1008);
    end
    step();
    budget = 1;
    exp_gnt.push_back(32'h1008);
    sb.push_back(32'h1008);
    wait_drain(100);
    @(negedge clk_i);
    check("stall_next", 64'(imem_addr_o), 64'h100C);

    // PC wrap at the top of the address space; redirect gates req
    step();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFF;
    @(negedge clk_i);
    check("redir_req_gate", 64'(imem_req_o), 64'd0);
    step();
    redirect_i = 1'b0;
    budget     = 2;
    exp_gnt.push_back(32'hFFFF_FFFC);
    exp_gnt.push_back(32'h0);
    sb.push_back(32'hFFFF_FFFC);
    sb.push_back(32'h0);
    @(negedge clk_i);
    check("wrap_addr", 64'(imem_addr_o), 64'hFFFF_FFFC);
    wait_drain(100);
    @(negedge clk_i);
    check("wrap_next", 64'(imem_addr_o), 64'h4);

    // Reset with one buffered instruction and one request outstanding
    step();
    fetch_ready_i = 1'b0;
    budget        = 2;
    exp_gnt.push_back(32'h4);
    exp_gnt.push_back(32'h8);
    @(posedge clk_i);
    step();
    resp_en = 1'b0;
    @(negedge clk_i);
    check("pre_rst_valid", 64'(fetch_valid_o), 64'd1);
    check("pre_rst_head",  64'(fetch_addr_o),  64'h4);
    check("pre_rst_req",   64'(imem_req_o),    64'd0);
    step();
    rst_i = 1'b1;
    @(negedge clk_i);
    check("mid_rst_req",   64'(imem_req_o),    64'd0);
    check("mid_rst_valid", 64'(fetch_valid_o), 64'd0);
    check("mid_rst_rdata", 64'(fetch_rdata_o), 64'd0);
    check("mid_rst_addr",  64'(fetch_addr_o),  64'd0);
    step();
    pend.delete();
    @(negedge clk_i);
    check("mid_rst_valid2", 64'(fetch_valid_o), 64'd0);
    step();
    rst_i         = 1'b0;
    resp_en       = 1'b1;
    fetch_ready_i = 1'b1;
    pend.push_back('{addr: 32'h8, due: 0});
    @(negedge clk_i);
    check("post_rst_req",   64'(imem_req_o),    64'd1);
    check("post_rst_addr",  64'(imem_addr_o),   64'(BOOT));
    check("post_rst_valid", 64'(fetch_valid_o), 64'd0);
    step();
    budget = 2;
    exp_gnt.push_back(32'h0);
    exp_gnt.push_back(32'h4);
    sb.push_back(32'h0);
    sb.push_back(32'h4);
    wait_drain(100);

    // Redirect flushes a full FIFO
    fetch_ready_i = 1'b0;
    budget        = 2;
    exp_gnt.push_back(32'h8);
    exp_gnt.push_back(32'hC);
    repeat (5) step();
    @(negedge clk_i);
    check("full_valid", 64'(fetch_valid_o), 64'd1);
    check("full_head",  64'(fetch_addr_o),  64'h8);
    step();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_2000;
    step();
    redirect_i    = 1'b0;
    fetch_ready_i = 1'b1;
    budget        = 1;
    exp_gnt.push_back(32'h2000);
    sb.push_back(32'h2000);
    @(negedge clk_i);
    check("flush_valid", 64'(fetch_valid_o), 64'd0);
    check("flush_addr",  64'(imem_addr_o),   64'h2000);
    wait_drain(100);

    check("idle_pend", 64'(pend.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
